mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, memory address width.
REQ-002 SHALL have parameter DATA_W, default 16, memory data width.
REQ-003 SHALL have port clock, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port f_req, input, 1, fetch requester read request; held until f_gnt.
REQ-006 SHALL have port f_addr, input, ADDR_W, fetch address; stable while f_req is high.
REQ-007 SHALL have ports f_gnt (output, 1), f_rvalid (output, 1) and f_rdata (output, DATA_W): grant pulse, read-data-valid pulse, read data.
REQ-008 SHALL have port d_req, input, 1, data requester request; held until d_gnt.
REQ-009 SHALL have ports d_we (input, 1), d_addr (input, ADDR_W) and d_wdata (input, DATA_W): write enable (1 = store, 0 = load), address, store data; all stable while d_req is high.
REQ-010 SHALL have ports d_gnt (output, 1), d_rvalid (output, 1) and d_rdata (output, DATA_W): grant pulse, completion pulse, load data.
REQ-011 SHALL have ports mem_address (output, ADDR_W), mem_data (output, DATA_W) and mem_wren (output, 1), driving the shared single-port memory.
REQ-012 SHALL have port mem_q, input, DATA_W, memory read data, valid in the cycle after the memory samples its address.
REQ-013 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-014 SHALL implement a three-state machine: IDLE, ACCESS, RESP.
REQ-015 IDLE transitions: no request -> remain IDLE; any request at a rising edge -> ACCESS.
REQ-016 On the IDLE -> ACCESS edge, SHALL register the winner's address into mem_address.
REQ-017 On the same edge, SHALL register mem_wren = d_we for a data winner and 0 for a fetch winner.
REQ-018 On the same edge, SHALL register mem_data = d_wdata for a data store and hold its previous value otherwise.
REQ-019 On the same edge, SHALL pulse the winner's gnt high for exactly one cycle.
REQ-020 ACCESS -> RESP SHALL be unconditional after one cycle; mem_wren SHALL fall on this edge, and mem_address and mem_data SHALL hold.
REQ-021 RESP -> IDLE SHALL be unconditional; on this edge the winner's rvalid SHALL pulse for one cycle.
REQ-022 On a read, the winner's rdata SHALL load mem_q on the RESP -> IDLE edge and hold until that requester's next read completes.
REQ-023 On a store, d_rvalid SHALL still pulse and d_rdata SHALL remain unchanged.
REQ-024 Latency: request sampled at edge N -> gnt high during cycle N+1 -> rvalid high during cycle N+3; next grant no earlier than edge N+3.
REQ-025 Requests arriving in ACCESS or RESP SHALL be ignored until IDLE; no request is lost while the requester holds req.
REQ-026 A requester SHALL NOT be granted twice for one transaction; the arbiter SHALL not track a req held across its own gnt and SHALL treat it as a new request.
REQ-027 f_rdata and d_rdata SHALL never be written by the other requester's transaction.

Reset
REQ-028 While reset is high, state SHALL be IDLE and mem_address, mem_data, f_rdata and d_rdata SHALL be 0.
REQ-029 While reset is high, mem_wren, f_gnt, d_gnt, f_rvalid, d_rvalid and busy SHALL be 0, and the arbitration pointer SHALL favour fetch.
REQ-030 Reset asserted mid-transaction SHALL abort it immediately, producing no rvalid; requesters re-request after reset.

Configuration
REQ-031 Macro MEM_ARB_ROUND_ROBIN_EN defined: on simultaneous f_req and d_req in IDLE, SHALL grant the requester not granted last (fetch after reset); a lone request always wins.
REQ-032 Macro undefined: SHALL apply fixed priority, data over fetch, on simultaneous requests; no pointer state.

Verification
REQ-033 f_req=1, f_addr=0x0010, mem_q returns 0xBEEF -> f_gnt one-cycle pulse at N+1, mem_wren=0, f_rvalid at N+3, f_rdata=0xBEEF.
REQ-034 d_req=1, d_we=1, d_addr=0x0040, d_wdata=0x1234 -> mem_wren=1 for exactly one cycle with mem_address=0x0040 and mem_data=0x1234; d_rvalid pulses; d_rdata unchanged.
REQ-035 f_req and d_req both held continuously from reset -> with the macro, grants alternate F,D,F,D; without the macro, only D is granted while d_req stays high.
REQ-036 d_req raised during ACCESS of a fetch -> d_gnt no earlier than the edge after f_rvalid's rising edge; f_rdata is the fetch value and d_rdata is untouched.
REQ-037 reset asserted during ACCESS of a store -> mem_wren drops asynchronously, no d_rvalid, all outputs 0, state IDLE.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Arbitrates a fetch requester and a data requester onto one shared
//   single-port synchronous memory. Each transaction walks IDLE -> ACCESS ->
//   RESP -> IDLE: the address (and store data / write enable) is registered
//   when the request is accepted, the memory samples it at the end of ACCESS,
//   and mem_q is captured into the winner's read-data register at the end of
//   RESP.
//
//   Configuration macro: MEM_ARB_ROUND_ROBIN_EN
//     defined   -> simultaneous requests alternate (fetch favoured after reset)
//     undefined -> fixed priority, data over fetch
//
// Ports
//   clock, reset              : single clock, asynchronous active-high reset
//   f_req, f_addr             : fetch read request (held until f_gnt)
//   f_gnt, f_rvalid, f_rdata  : fetch grant pulse, completion pulse, read data
//   d_req, d_we, d_addr,
//   d_wdata                   : data request (store when d_we = 1)
//   d_gnt, d_rvalid, d_rdata  : data grant pulse, completion pulse, load data
//   mem_address, mem_data,
//   mem_wren, mem_q           : shared memory port (mem_q valid one cycle
//                               after the address is sampled)
//   busy                      : high whenever a transaction is in flight
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              f_req,
   input  logic [ADDR_W-1:0] f_addr,
   output logic              f_gnt,
   output logic              f_rvalid,
   output logic [DATA_W-1:0] f_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_data,
   output logic              mem_wren,
   input  logic [DATA_W-1:0] mem_q,
   output logic              busy
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RESP   = 2'd2
   } state_t;

   state_t r_state;
   state_t w_next_state;
   logic   w_any_req;
   logic   w_win_d;     // 1 = data requester wins this arbitration
   logic   r_owner_d;   // owner of the transaction in flight
   logic   r_store;     // transaction in flight is a store (no read data)

`ifdef MEM_ARB_ROUND_ROBIN_EN
   logic   r_prefer_d;  // 1 = data wins the next tie; reset favours fetch
`endif

   assign w_any_req = f_req | d_req;
   assign busy      = (r_state != S_IDLE);

   // NOTE: every signal written here gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      w_next_state = r_state;
      w_win_d      = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      w_win_d      = d_req & (~f_req | r_prefer_d);
`else
      w_win_d      = d_req;
`endif
      case (r_state)
         S_IDLE:   if (w_any_req) w_next_state = S_ACCESS;
         S_ACCESS: w_next_state = S_RESP;
         S_RESP:   w_next_state = S_IDLE;
         default:  w_next_state = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next_state;
   end

   // Datapath and handshake registers. The async reset clears everything,
   // which also aborts a transaction in flight without an rvalid.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_owner_d   <= 1'b0;
         r_store     <= 1'b0;
         mem_address <= '0;
         mem_data    <= '0;
         mem_wren    <= 1'b0;
         f_gnt       <= 1'b0;
         d_gnt       <= 1'b0;
         f_rvalid    <= 1'b0;
         d_rvalid    <= 1'b0;
         f_rdata     <= '0;
         d_rdata     <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
         r_prefer_d  <= 1'b0;
`endif
      end else begin
         // Grants and completions are single-cycle pulses.
         f_gnt    <= 1'b0;
         d_gnt    <= 1'b0;
         f_rvalid <= 1'b0;
         d_rvalid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_any_req) begin
                  r_owner_d   <= w_win_d;
                  r_store     <= w_win_d & d_we;
                  mem_address <= w_win_d ? d_addr : f_addr;
                  mem_wren    <= w_win_d & d_we;
                  // mem_data only moves for a store; loads leave it alone.
                  if (w_win_d && d_we) mem_data <= d_wdata;
                  f_gnt       <= ~w_win_d;
                  d_gnt       <= w_win_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                  r_prefer_d  <= ~w_win_d;
`endif
               end
            end
            S_ACCESS: begin
               // The memory samples address/data/wren on this edge.
               mem_wren <= 1'b0;
            end
            S_RESP: begin
               // mem_q now reflects the address sampled at the end of ACCESS.
               if (r_owner_d) begin
                  d_rvalid <= 1'b1;
                  if (!r_store) d_rdata <= mem_q;
               end else begin
                  f_rvalid <= 1'b1;
                  f_rdata  <= mem_q;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
